// File: rtl/seq_alu.sv
// seq_alu: registered ALU with start/busy/done handshake, N/V/C/Z flags and a shift-add multiply
module seq_alu #(
  parameter int WIDTH = 8,
  parameter int CNTW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [7:0]       sreg
);
  localparam logic [3:0] OP_COM = 4'b0001, OP_SUB = 4'b0010, OP_MUL = 4'b0011, OP_NEG = 4'b0100,
                         OP_INC = 4'b0101, OP_LSR = 4'b0110, OP_LSL = 4'b0111, OP_MOV = 4'b1000,
                         OP_ADD = 4'b1010, OP_ADC = 4'b1011, OP_AND = 4'b1100, OP_OR  = 4'b1101;
  typedef enum logic {IDLE, MUL_RUN} state_t;
  state_t state, state_n;
  logic [CNTW-1:0] cnt;
  logic [2*WIDTH-1:0] acc, mcand, prod;
  logic [WIDTH-1:0] mplier, r;
  logic [WIDTH:0] sum, diff;
  logic [3:0] f;
  logic wr;
  always_comb begin
    state_n = (state == IDLE) ? ((start && op == OP_MUL) ? MUL_RUN : IDLE)
                              : ((cnt == CNTW'(1)) ? IDLE : MUL_RUN);
    prod = acc + (mplier[0] ? mcand : '0);
  end
  always_comb begin
    sum = {1'b0, in1} + {1'b0, in2} + (WIDTH+1)'(op == OP_ADC && sreg[0]);
    diff = {1'b0, in1} - {1'b0, in2};
    r = result;
    f = sreg[3:0];
    wr = 1'b1;
    case (op)
      OP_COM: begin r = ~in1; f = {1'b0, r[WIDTH-1], ~|r, 1'b1}; end
      OP_SUB: begin
        r = diff[WIDTH-1:0];
        f = {(in1[WIDTH-1] != in2[WIDTH-1]) && (r[WIDTH-1] != in1[WIDTH-1]), r[WIDTH-1], ~|r, diff[WIDTH]};
      end
      OP_NEG: begin r = '0 - in1; f = {r == {1'b1, {(WIDTH-1){1'b0}}}, r[WIDTH-1], ~|r, |r}; end
      OP_INC: begin r = in1 + WIDTH'(1); f = {in1 == {1'b0, {(WIDTH-1){1'b1}}}, r[WIDTH-1], ~|r, sreg[0]}; end
      OP_LSR: begin r = in1 >> 1; f = {in1[0], 1'b0, ~|r, in1[0]}; end
      OP_LSL: begin r = in1 << 1; f = {r[WIDTH-1] ^ in1[WIDTH-1], r[WIDTH-1], ~|r, in1[WIDTH-1]}; end
      OP_MOV: r = in2;
      OP_ADD, OP_ADC: begin
        r = sum[WIDTH-1:0];
        f = {(in1[WIDTH-1] == in2[WIDTH-1]) && (r[WIDTH-1] != in1[WIDTH-1]), r[WIDTH-1], ~|r, sum[WIDTH]};
      end
      OP_AND: begin r = in1 & in2; f = {1'b0, r[WIDTH-1], ~|r, sreg[0]}; end
      OP_OR:  begin r = in1 | in2; f = {1'b0, r[WIDTH-1], ~|r, sreg[0]}; end
      default: wr = 1'b0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      result <= '0;
      result_hi <= '0;
      sreg <= '0;
    end else begin
      state <= state_n;
      done <= 1'b0;
      if (state == IDLE && start) begin
        if (op == OP_MUL) begin
          mcand <= {{WIDTH{1'b0}}, in1};
          mplier <= in2;
          acc <= '0;
          cnt <= CNTW'(WIDTH);
          busy <= 1'b1;
        end else begin
          done <= 1'b1;
          if (wr) begin
            result <= r;
            result_hi <= '0;
            sreg <= {4'b0, f};
          end
        end
      end else if (state == MUL_RUN) begin
        acc <= prod;
        mcand <= mcand << 1;
        mplier <= mplier >> 1;
        cnt <= cnt - CNTW'(1);
        if (cnt == CNTW'(1)) begin
          result <= prod[WIDTH-1:0];
          result_hi <= prod[2*WIDTH-1:WIDTH];
          sreg <= {4'b0, sreg[3], sreg[2], ~|prod, |prod[2*WIDTH-1:WIDTH]};
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed and random checks of seq_alu against an arithmetic reference model
module tb_seq_alu;
  localparam int W = 8;
  localparam int M = 256;
  localparam int H = 128;
  logic clk = 1'b0;
  logic rst, start, busy, done;
  logic [3:0] op;
  logic [W-1:0] in1, in2, result, result_hi;
  logic [7:0] sreg;
  int n_cmp, n_err;
  int m_r, m_hi, m_c, m_z, m_n, m_v;
  seq_alu #(.WIDTH(W), .CNTW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .in1(in1), .in2(in2),
    .busy(busy), .done(done), .result(result), .result_hi(result_hi), .sreg(sreg)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int sgn(input int x);
    return x >= H ? x - M : x;
  endfunction
  function automatic int ovf(input int x);
    return (x < -H || x >= H) ? 1 : 0;
  endfunction
  task automatic clr_model();
    m_r = 0; m_hi = 0; m_c = 0; m_z = 0; m_n = 0; m_v = 0;
  endtask
  task automatic model(input int o, input int a, input int b);
    int r, s, cin;
    r = 0;
    case (o)
      1: begin r = (~a) & (M - 1); m_c = 1; m_v = 0; end
      2: begin r = (a - b + M) % M; m_c = (b > a); m_v = ovf(sgn(a) - sgn(b)); end
      3: begin
        s = a * b;
        m_r = s % M; m_hi = s / M; m_z = (s == 0); m_c = (m_hi != 0);
        return;
      end
      4: begin r = (M - a) % M; m_c = (r != 0); m_v = ovf(-sgn(a)); end
      5: begin r = (a + 1) % M; m_v = ovf(sgn(a) + 1); end
      6: begin r = a / 2; m_c = a % 2; m_v = m_c; end
      7: begin r = (a * 2) % M; m_c = (a >= H); end
      8: r = b;
      10, 11: begin
        cin = (o == 11) ? m_c : 0;
        s = a + b + cin;
        r = s % M; m_c = (s >= M); m_v = ovf(sgn(a) + sgn(b) + cin);
      end
      12: begin r = a & b; m_v = 0; end
      13: begin r = a | b; m_v = 0; end
      default: return;
    endcase
    m_r = r;
    m_hi = 0;
    if (o != 8) begin m_z = (r == 0); m_n = (r >= H); end
    if (o == 7) m_v = m_n ^ m_c;
  endtask
  task automatic check_outs(input string tag);
    chk({tag, "_result"}, result, m_r);
    chk({tag, "_result_hi"}, result_hi, m_hi);
    chk({tag, "_sreg"}, sreg, m_v * 8 + m_n * 4 + m_z * 2 + m_c);
  endtask
  task automatic run_op(input int o, input int a, input int b, input bit poke);
    int cyc;
    model(o, a, b);
    start = 1'b1; op = 4'(o); in1 = W'(a); in2 = W'(b);
    @(posedge clk); #1;
    start = 1'b0; op = 4'($urandom); in1 = W'($urandom); in2 = W'($urandom);
    if (o == 3) begin
      chk("mul_busy_set", busy, 1);
      chk("mul_done_early", done, 0);
      cyc = 0;
      while (busy && cyc < 40) begin
        cyc++;
        if (poke && cyc == 3) begin start = 1'b1; op = 4'b1010; end
        @(posedge clk); #1;
        start = 1'b0;
        if (busy) chk("mul_done_mid", done, 0);
      end
      chk("mul_busy_cycles", cyc, W);
    end
    chk("done_pulse", done, 1);
    check_outs("op");
  endtask
  task automatic do_reset(input int n, input bit with_start);
    rst = 1'b1; start = with_start; op = 4'b1010; in1 = 8'h01; in2 = 8'h02;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0;
    clr_model();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    check_outs("rst");
    @(posedge clk); #1;
    chk("rst_done_after", done, 0);
    check_outs("rst_after");
  endtask
  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; start = 1'b0; op = '0; in1 = '0; in2 = '0;
    clr_model();
    @(posedge clk); #1;
    do_reset(2, 1'b0);
    run_op(10, 'hFF, 'h01, 0);
    run_op(11, 'h10, 'h20, 0);
    run_op(2, 'h80, 'h01, 0);
    run_op(2, 'h01, 'h02, 0);
    run_op(4, 'h80, 'h00, 0);
    run_op(3, 'hFF, 'hFF, 1);
    start = 1'b1; op = 4'b0011; in1 = 8'h33; in2 = 8'h44;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      chk("abort_busy", busy, 1);
      chk("abort_done", done, 0);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clr_model();
    chk("abort_rst_busy", busy, 0);
    chk("abort_rst_done", done, 0);
    check_outs("abort");
    repeat (W) begin
      @(posedge clk); #1;
      chk("abort_no_done", done, 0);
    end
    run_op(3, 'h0C, 'h0A, 0);
    run_op(7, 'h81, 'h00, 0);
    run_op(12, 'h0F, 'hF0, 0);
    run_op(8, 'h00, 'h55, 0);
    run_op(14, 'h12, 'h34, 0);
    run_op(5, 'h7F, 'h00, 0);
    run_op(6, 'h01, 'h00, 0);
    do_reset(2, 1'b1);
    for (int i = 0; i < 300; i++) begin
      run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, M - 1)),
             int'($urandom_range(0, M - 1)), $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
        chk("idle_done", done, 0);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
